// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the register-file write arbiter
package regfile_pkg;

  // Number of requesters sharing the register-file write port
  localparam int NREQ  = 4;
  // Width of the round-robin pointer and winner index
  localparam int PTR_W = $clog2(NREQ);
  // Width of the committed-write counter
  localparam int CNT_W = 8;

  // Arbiter FSM states; CLEAR is only reachable when the clear feature is built in
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } arb_state_e;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// rtl/regfile_wr_arbiter_if.sv - requester and register-file write-port bundle
interface regfile_wr_arbiter_if
  import regfile_pkg::*;
#(
  parameter int w1 = 2,
  parameter int w2 = 8
) ();

  logic [NREQ-1:0]      req;
  logic [NREQ*w1-1:0]   wa;
  logic [NREQ*w2-1:0]   wd;
  logic                 clr_all;
  logic [NREQ-1:0]      gnt;
  logic                 busy;
  logic [w1-1:0]        s;
  logic                 e;
  logic [w2-1:0]        d;
  logic [(1<<w1)-1:0]   clr;
  logic [CNT_W-1:0]     wr_cnt;

  // Requester side: drives requests, observes grants and the write port
  modport master (
    output req, wa, wd, clr_all,
    input  gnt, busy, s, e, d, clr, wr_cnt
  );

  // Arbiter side
  modport slave (
    input  req, wa, wd, clr_all,
    output gnt, busy, s, e, d, clr, wr_cnt
  );

endinterface

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// rtl/regfile_wr_arbiter_rr_pick.sv - combinational round-robin winner selection
module rr_pick
  import regfile_pkg::*;
(
  input  logic [NREQ-1:0]  i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_gnt,
  output logic [PTR_W-1:0] o_idx
);

  // Scan from the farthest offset down to offset 0 so the requester at ptr has highest priority
  always_comb begin
    logic [PTR_W-1:0] w_cand;
    o_gnt  = '0;
    o_idx  = '0;
    w_cand = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_cand = i_ptr + PTR_W'(i);
      if (i_req[w_cand]) begin
        o_gnt         = '0;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin write-port arbiter; optional clear-all via REGFILE_WRARB_CLEAR_EN
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int w1 = 2,
  parameter int w2 = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wr_arbiter_if.slave   bus
);

  localparam int NREG = 1 << w1;

  arb_state_e       r_state, w_state_nxt;
  logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
  logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
  logic             r_busy, w_busy_nxt;
  logic [w1-1:0]    r_s, w_s_nxt;
  logic             r_e, w_e_nxt;
  logic [w2-1:0]    r_d, w_d_nxt;
  logic [NREG-1:0]  r_clr, w_clr_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic [NREQ-1:0]  w_pick_gnt;
  logic [PTR_W-1:0] w_pick_idx;
  logic             w_clr_req;

  rr_pick u_rr_pick (
    .i_req (bus.req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx)
  );

`ifdef REGFILE_WRARB_CLEAR_EN
  assign w_clr_req = bus.clr_all;
`else
  // Port kept for a uniform interface; the request is ignored in this build
  logic w_unused_clr_all;
  assign w_unused_clr_all = bus.clr_all;
  assign w_clr_req        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next registered outputs; s/d hold the last granted values
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = '0;
    w_busy_nxt  = 1'b0;
    w_s_nxt     = r_s;
    w_e_nxt     = 1'b0;
    w_d_nxt     = r_d;
    w_clr_nxt   = '0;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_clr_req) begin
          // Clear takes priority; pending requests keep waiting in IDLE
          w_state_nxt = ST_CLEAR;
          w_clr_nxt   = '1;
          w_busy_nxt  = 1'b1;
        end else if (|bus.req) begin
          w_state_nxt = ST_WRITE;
          w_gnt_nxt   = w_pick_gnt;
          w_busy_nxt  = 1'b1;
          w_e_nxt     = 1'b1;
          w_s_nxt     = bus.wa[w_pick_idx*w1 +: w1];
          w_d_nxt     = bus.wd[w_pick_idx*w2 +: w2];
          w_ptr_nxt   = w_pick_idx + PTR_W'(1);
        end
      end
      ST_WRITE: begin
        // The register file captures the write on this edge, so it is committed here
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output, pointer and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr  <= '0;
      r_gnt  <= '0;
      r_busy <= 1'b0;
      r_s    <= '0;
      r_e    <= 1'b0;
      r_d    <= '0;
      r_clr  <= '0;
      r_cnt  <= '0;
    end else begin
      r_ptr  <= w_ptr_nxt;
      r_gnt  <= w_gnt_nxt;
      r_busy <= w_busy_nxt;
      r_s    <= w_s_nxt;
      r_e    <= w_e_nxt;
      r_d    <= w_d_nxt;
      r_clr  <= w_clr_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.busy   = r_busy;
  assign bus.s      = r_s;
  assign bus.e      = r_e;
  assign bus.d      = r_d;
  assign bus.clr    = r_clr;
  assign bus.wr_cnt = r_cnt;

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Round-robin controller that shares the single write port of the register file (`s`/`e`/`d`/`clr`) between four independent requesters. It accepts one request at a time and drives a registered, one-cycle write strobe into the register file. It also keeps a count of committed writes. It sits directly in front of the register file and shares that block's `clk` and `rst`.

## Interface
- `w1`, default 2: register address width; the register file holds 2**w1 registers.
- `w2`, default 8: data width.
- `clk`  input  1: clock; all state updates on the rising edge.
- `rst`  input  1: reset, synchronous, active-high.
- `req`  input  4: request, one bit per requester; level, held until granted.
- `wa`  input  4*w1: write addresses; requester i occupies bits [i*w1 +: w1].
- `wd`  input  4*w2: write data; requester i occupies bits [i*w2 +: w2].
- `clr_all`  input  1: request to clear all registers (see Configuration).
- `gnt`  output  4: one-hot grant, high for exactly one cycle.
- `busy`  output  1: high while the FSM is not in IDLE.
- `s`  output  w1: register file write select.
- `e`  output  1: register file write enable.
- `d`  output  w2: register file write data.
- `clr`  output  2**w1: register file per-register clear.
- `wr_cnt`  output  8: number of committed writes.

## Operation
- FSM states are IDLE, WRITE and CLEAR. All outputs are registered.
- Reset values are state=IDLE, ptr=0, gnt=0, busy=0, s=0, e=0, d=0, clr=0, wr_cnt=0.
- IDLE with no request: outputs hold, e=0, gnt=0.
- IDLE with any `req` bit set: select winner k by searching ptr, ptr+1, … modulo 4. Next state is WRITE, with s=wa[k], d=wd[k], e=1, gnt=onehot(k), busy=1, ptr=(k+1) mod 4.
- WRITE always returns to IDLE after one cycle, with e=0, gnt=0, busy=0 and wr_cnt+1. No arbitration happens in WRITE.
- wr_cnt wraps from 255 to 0.
- s and d keep the last granted values while e=0.
- A requester must drop `req` before the second rising edge after `gnt` is raised. A request still asserted then is treated as a new request.
- Requests are not queued. Only the `req` level present in IDLE is sampled.

## Timing
- Request sampled at edge T causes e, s, d and gnt to become valid after edge T. The register file captures the write at edge T+1.
- Maximum throughput is one write every 2 cycles.
- `rst` asserted in any state forces all reset values at the next edge. A write in progress is not counted; the register file is reset by the same `rst`.
- If `req` and `clr_all` are both present in IDLE, `clr_all` wins and the requests wait.
- If `req`=0 and `clr_all`=0, nothing changes.

## Configuration
- `REGFILE_WRARB_CLEAR_EN` defined:
  - `clr_all` sampled high in IDLE moves the FSM to CLEAR, driving clr all-ones, e=0, gnt=0 and busy=1 for one cycle.
  - CLEAR then returns to IDLE with clr=0.
  - wr_cnt is unchanged.
- Not defined:
  - The CLEAR state is absent.
  - The `clr_all` port remains but is ignored.
  - clr is constant 0.

## Structure
- The shared package `regfile_pkg` holds:
  - the FSM state enum (IDLE/WRITE/CLEAR);
  - the constant NREQ=4;
  - the width of wr_cnt (8).
- One sub-module, `rr_pick`, is combinational. It takes `req` and `ptr` and returns the one-hot winner and its index.
- The FSM, the pointer, the output registers and the counter live in the top level.

## Test plan
- Reset check: hold rst for 2 cycles with random inputs, then confirm every output is 0 and busy=0.
- Single write: req=4'b0100, wa[5:4]=2'b10, wd[23:16]=8'h04.
  - One cycle later: e=1, s=2, d=8'h04, gnt=4'b0100.
  - The cycle after: e=0, wr_cnt=1.
- Fairness: all four requesters re-raise `req` right after each grant. Grants must come in the order 0, 1, 2, 3, 0, with e high on every other cycle.
- Wrap of the pointer: after a grant to requester 1 (ptr=2), apply req=4'b0011. The grant must be 4'b0001 and ptr must become 1.
- Clear priority (macro defined): in IDLE, apply clr_all=1 and req=4'b0010 together.
  - One cycle of clr=4'b1111 with e=0.
  - Then IDLE, then a grant of 4'b0010.
- Reset mid-write: assert rst during WRITE after wr_cnt=3. The next cycle must show e=0, gnt=0, wr_cnt=0 and ptr=0.
